// File: rtl/lsu_pipe_pkg.sv
// Shared types and helpers for the pipelined load/store unit.
package lsu_pipe_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_D = 2'b11
    } lsu_size_e;

    function automatic logic [3:0] lsu_bytes(input lsu_size_e sz);
        case (sz)
            LSU_SIZE_B: lsu_bytes = 4'd1;
            LSU_SIZE_H: lsu_bytes = 4'd2;
            LSU_SIZE_W: lsu_bytes = 4'd4;
            default:    lsu_bytes = 4'd8;
        endcase
    endfunction

    function automatic logic lsu_misaligned(input lsu_size_e sz, input logic [2:0] a);
        case (sz)
            LSU_SIZE_B: lsu_misaligned = 1'b0;
            LSU_SIZE_H: lsu_misaligned = a[0];
            LSU_SIZE_W: lsu_misaligned = |a[1:0];
            default:    lsu_misaligned = |a;
        endcase
    endfunction

endpackage

// File: rtl/lsu_pipe_if.sv
// Data-port bus between the LSU (master) and memory (slave): req/gnt with in-order rvalid.
interface lsu_pipe_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  req;
    logic                  gnt;
    logic [ADDR_W-1:0]     addr;
    logic                  we;
    logic [DATA_W/8-1:0]   be;
    logic [DATA_W-1:0]     wdata;
    logic                  rvalid;
    logic [DATA_W-1:0]     rdata;

    modport master (output req, addr, we, be, wdata, input gnt, rvalid, rdata);
    modport slave  (input req, addr, we, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_inflight_fifo.sv
// In-order tracker of granted bus transactions; head is the op the next rvalid answers.
module lsu_inflight_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 8,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  din_i,
    output logic [W-1:0]  dout_o,
    output logic [CW-1:0] cnt_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    // A pop on an empty FIFO is a protocol error and is dropped.
    assign do_pop  = pop_i && (cnt_q != '0);
    assign do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= (wr_q == AW'(DEPTH - 1)) ? '0 : wr_q + 1'b1;
            if (do_pop)  rd_q <= (rd_q == AW'(DEPTH - 1)) ? '0 : rd_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    assign dout_o = mem_q[rd_q];
    assign cnt_o  = cnt_q;
endmodule

// File: rtl/lsu_pipe.sv
// Pipelined LSU: AGU + hold register toward the bus, in-flight tracking, load align/extend, writeback.
module lsu_pipe
    import lsu_pipe_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int OUTSTANDING = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [ADDR_W-1:0]     req_op1_i,
    input  logic [ADDR_W-1:0]     req_op2_i,
    input  logic [DATA_W-1:0]     req_wdata_i,
    input  logic [1:0]            req_size_i,
    input  logic                  req_unsigned_i,
    input  logic                  req_store_i,
    input  logic [REG_ADDR_W-1:0] req_rd_i,
    input  logic                  int_assert_i,
    lsu_pipe_if.master            mem_if,
    output logic                  wb_valid_o,
    output logic [REG_ADDR_W-1:0] wb_rd_o,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  misalign_o,
    output logic [ADDR_W-1:0]     misalign_addr_o,
    output logic                  busy_o
);
    localparam int BE_W   = DATA_W / 8;
    localparam int OFF_W  = $clog2(BE_W);
    localparam int CNT_W  = $clog2(OUTSTANDING + 1);
    localparam int FIFO_W = 1 + REG_ADDR_W + OFF_W + 2 + 1;

    logic [ADDR_W-1:0]     addr;
    lsu_size_e             size;
    logic [3:0]            nbytes;
    logic                  mis, accept, grant, pop_ok;
    logic [CNT_W-1:0]      cnt;
    logic [BE_W-1:0]       be_d;
    logic [DATA_W-1:0]     wdata_d;

    logic                  hold_q, we_q, uns_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [BE_W-1:0]       be_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [OFF_W-1:0]      off_q;
    logic [1:0]            size_q;

    assign addr   = req_op1_i + req_op2_i;
    assign size   = lsu_size_e'(req_size_i);
    assign nbytes = lsu_bytes(size);
    assign mis    = lsu_misaligned(size, addr[2:0]);
    assign grant  = hold_q && mem_if.gnt;

    // No credit for a same-cycle pop: a slot is only reusable once the count has dropped.
    assign req_ready_o = !int_assert_i && (!hold_q || mem_if.gnt) &&
                         ((int'(cnt) + int'(hold_q)) < OUTSTANDING);
    assign accept      = req_valid_i && req_ready_o;

    always_comb begin
        logic [7:0] mask;
        case (size)
            LSU_SIZE_B: mask = 8'h01;
            LSU_SIZE_H: mask = 8'h03;
            LSU_SIZE_W: mask = 8'h0F;
            default:    mask = 8'hFF;
        endcase
        be_d = mask[BE_W-1:0] << addr[OFF_W-1:0];
        wdata_d = '0;
        for (int i = 0; i < BE_W; i++)
            wdata_d[8*i +: 8] = req_wdata_i[8*(i & (int'(nbytes) - 1)) +: 8];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_q  <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            off_q   <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
        end else if (accept && !mis) begin
            hold_q  <= 1'b1;
            addr_q  <= addr;
            we_q    <= req_store_i;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rd_q    <= req_rd_i;
            off_q   <= addr[OFF_W-1:0];
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
        end else if (grant) begin
            hold_q  <= 1'b0;
        end
    end

    assign mem_if.req   = hold_q;
    assign mem_if.addr  = addr_q;
    assign mem_if.we    = we_q;
    assign mem_if.be    = be_q;
    assign mem_if.wdata = wdata_q;

    logic [FIFO_W-1:0]     head;
    logic                  h_store, h_uns;
    logic [REG_ADDR_W-1:0] h_rd;
    logic [OFF_W-1:0]      h_off;
    logic [1:0]            h_size;

    lsu_inflight_fifo #(.DEPTH(OUTSTANDING), .W(FIFO_W)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push_i (grant),
        .pop_i  (mem_if.rvalid),
        .din_i  ({we_q, rd_q, off_q, size_q, uns_q}),
        .dout_o (head),
        .cnt_o  (cnt)
    );

    assign {h_store, h_rd, h_off, h_size, h_uns} = head;
    assign pop_ok = mem_if.rvalid && (cnt != '0);

    logic [DATA_W-1:0] sh, ld_d;
    logic              ext;
    int                nb;

    always_comb begin
        sh = mem_if.rdata >> {h_off, 3'b000};
        case (lsu_size_e'(h_size))
            LSU_SIZE_B: begin nb = 8;      ext = sh[7];        end
            LSU_SIZE_H: begin nb = 16;     ext = sh[15];       end
            LSU_SIZE_W: begin nb = 32;     ext = sh[31];       end
            default:    begin nb = DATA_W; ext = sh[DATA_W-1]; end
        endcase
        ext = ext && !h_uns;
        for (int i = 0; i < DATA_W; i++)
            ld_d[i] = (i < nb) ? sh[i] : ext;
    end

    logic                  wb_valid_q, mis_q;
    logic [REG_ADDR_W-1:0] wb_rd_q;
    logic [DATA_W-1:0]     wb_data_q;
    logic [ADDR_W-1:0]     mis_addr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            mis_q      <= 1'b0;
            mis_addr_q <= '0;
        end else begin
            wb_valid_q <= pop_ok && !h_store && (h_rd != '0);
            if (pop_ok && !h_store) begin
                wb_rd_q   <= h_rd;
                wb_data_q <= ld_d;
            end
            mis_q <= accept && mis;
            if (accept && mis) mis_addr_q <= addr;
        end
    end

    assign wb_valid_o      = wb_valid_q;
    assign wb_rd_o         = wb_rd_q;
    assign wb_data_o       = wb_data_q;
    assign misalign_o      = mis_q;
    assign misalign_addr_o = mis_addr_q;
    assign busy_o          = hold_q || (cnt != '0);
endmodule

// File: tb/tb_lsu_pipe.sv
// Directed bench for lsu_pipe (DATA_W=32, OUTSTANDING=2) with hand-computed expectations.
module tb_lsu_pipe;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i, req_ready_o, req_unsigned_i, req_store_i, int_assert_i;
    logic [31:0] req_op1_i, req_op2_i, req_wdata_i;
    logic [1:0]  req_size_i;
    logic [4:0]  req_rd_i, wb_rd_o;
    logic        wb_valid_o, misalign_o, busy_o;
    logic [31:0] wb_data_o, misalign_addr_o;
    int          n_pass = 0, n_total = 0;

    lsu_pipe_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_pipe #(.ADDR_W(32), .DATA_W(32), .REG_ADDR_W(5), .OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op1_i(req_op1_i), .req_op2_i(req_op2_i), .req_wdata_i(req_wdata_i),
        .req_size_i(req_size_i), .req_unsigned_i(req_unsigned_i), .req_store_i(req_store_i),
        .req_rd_i(req_rd_i), .int_assert_i(int_assert_i), .mem_if(bus),
        .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
        .misalign_o(misalign_o), .misalign_addr_o(misalign_addr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Present one op, require acceptance, take the accepting edge, then drop valid.
    task automatic issue(input logic [31:0] op1, op2, wd, input logic [1:0] sz,
                         input logic uns, st, input logic [4:0] rd);
        req_op1_i = op1; req_op2_i = op2; req_wdata_i = wd; req_size_i = sz;
        req_unsigned_i = uns; req_store_i = st; req_rd_i = rd; req_valid_i = 1'b1;
        #1;
        chk("issue_ready", req_ready_o, 1'b1);
        tick();
        req_valid_i = 1'b0;
    endtask

    task automatic grant1();
        bus.gnt = 1'b1; tick(); bus.gnt = 1'b0;
    endtask

    task automatic resp(input logic [31:0] d);
        bus.rvalid = 1'b1; bus.rdata = d; tick(); bus.rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; req_valid_i = 0; req_op1_i = 0; req_op2_i = 0; req_wdata_i = 0;
        req_size_i = 0; req_unsigned_i = 0; req_store_i = 0; req_rd_i = 0; int_assert_i = 0;
        bus.gnt = 0; bus.rvalid = 0; bus.rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_req", bus.req, 1'b0);
        chk("rst_mem_be", bus.be, 4'h0);
        chk("rst_wb_valid", wb_valid_o, 1'b0);
        chk("rst_misalign", misalign_o, 1'b0);
        chk("rst_mis_addr", misalign_addr_o, 32'h0);
        chk("rst_busy", busy_o, 1'b0);
        rst = 1'b1;
        tick();

        // lw 0x1000+4
        issue(32'h1000, 32'h4, 32'h0, 2'b10, 1'b0, 1'b0, 5'd5);
        chk("lw_req", bus.req, 1'b1);
        chk("lw_addr", bus.addr, 32'h1004);
        chk("lw_be", bus.be, 4'hF);
        chk("lw_we", bus.we, 1'b0);
        chk("lw_busy", busy_o, 1'b1);
        grant1();
        chk("lw_req_drop", bus.req, 1'b0);
        chk("lw_no_wb_yet", wb_valid_o, 1'b0);
        resp(32'hDEADBEEF);
        chk("lw_wb_valid", wb_valid_o, 1'b1);
        chk("lw_wb_rd", wb_rd_o, 5'd5);
        chk("lw_wb_data", wb_data_o, 32'hDEADBEEF);
        chk("lw_idle", busy_o, 1'b0);
        tick();
        chk("lw_wb_pulse", wb_valid_o, 1'b0);

        // lb / lbu at 0x1003
        issue(32'h1000, 32'h3, 32'h0, 2'b00, 1'b0, 1'b0, 5'd6);
        chk("lb_be", bus.be, 4'h8);
        grant1();
        resp(32'h80123456);
        chk("lb_wb_data", wb_data_o, 32'hFFFFFF80);
        chk("lb_wb_rd", wb_rd_o, 5'd6);
        issue(32'h1000, 32'h3, 32'h0, 2'b00, 1'b1, 1'b0, 5'd7);
        grant1();
        resp(32'h80123456);
        chk("lbu_wb_data", wb_data_o, 32'h00000080);

        // sh at 0x2002
        issue(32'h2000, 32'h2, 32'h1234ABCD, 2'b01, 1'b0, 1'b1, 5'd3);
        chk("sh_be", bus.be, 4'hC);
        chk("sh_wdata", bus.wdata, 32'hABCDABCD);
        chk("sh_we", bus.we, 1'b1);
        grant1();
        resp(32'h0);
        chk("sh_no_wb", wb_valid_o, 1'b0);
        chk("sh_idle", busy_o, 1'b0);

        // misaligned lw at 0x3001, then lh at 0x3002
        issue(32'h3000, 32'h1, 32'h0, 2'b10, 1'b0, 1'b0, 5'd8);
        chk("mis_no_req", bus.req, 1'b0);
        chk("mis_pulse", misalign_o, 1'b1);
        chk("mis_addr", misalign_addr_o, 32'h3001);
        chk("mis_not_busy", busy_o, 1'b0);
        tick();
        chk("mis_pulse_end", misalign_o, 1'b0);
        chk("mis_addr_held", misalign_addr_o, 32'h3001);
        issue(32'h3000, 32'h2, 32'h0, 2'b01, 1'b0, 1'b0, 5'd8);
        chk("lh_req", bus.req, 1'b1);
        chk("lh_be", bus.be, 4'hC);
        grant1();
        resp(32'h8001BEEF);
        chk("lh_wb_data", wb_data_o, 32'hFFFF8001);

        // Outstanding limit with gnt held high
        bus.gnt = 1'b1;
        issue(32'h4000, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 5'd9);
        issue(32'hFFFFFFFC, 32'h8, 32'h0, 2'b10, 1'b0, 1'b0, 5'd10);
        chk("os_wrap_addr", bus.addr, 32'h4);
        req_op1_i = 32'h5000; req_op2_i = 0; req_rd_i = 5'd11; req_valid_i = 1'b1; #1;
        chk("os_full_ready0", req_ready_o, 1'b0);
        tick();
        chk("os_cnt2_ready0", req_ready_o, 1'b0);
        chk("os_req_drop", bus.req, 1'b0);
        tick();
        bus.rvalid = 1'b1; bus.rdata = 32'h11111111; #1;
        chk("os_no_pop_credit", req_ready_o, 1'b0);
        tick();
        chk("os_wb1_rd", wb_rd_o, 5'd9);
        chk("os_wb1_data", wb_data_o, 32'h11111111);
        chk("os_ready_after_pop", req_ready_o, 1'b1);
        bus.rdata = 32'h22222222;
        tick();
        bus.rvalid = 1'b0; req_valid_i = 1'b0;
        chk("os_wb2_rd", wb_rd_o, 5'd10);
        chk("os_wb2_data", wb_data_o, 32'h22222222);
        chk("os_third_addr", bus.addr, 32'h5000);
        tick();
        bus.gnt = 1'b0;
        resp(32'h33333333);
        chk("os_wb3_rd", wb_rd_o, 5'd11);
        chk("os_wb3_data", wb_data_o, 32'h33333333);

        // Interrupt while a load is held
        issue(32'h6000, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 5'd12);
        int_assert_i = 1'b1; req_valid_i = 1'b1; req_op1_i = 32'h7000; #1;
        for (int c = 0; c < 3; c++) begin
            chk("int_ready0", req_ready_o, 1'b0);
            chk("int_req_held", bus.req, 1'b1);
            tick();
        end
        bus.gnt = 1'b1; #1;
        chk("int_ready0_gnt", req_ready_o, 1'b0);
        tick();
        bus.gnt = 1'b0;
        chk("int_req_drop", bus.req, 1'b0);
        resp(32'hCAFEF00D);
        chk("int_wb_valid", wb_valid_o, 1'b1);
        chk("int_wb_rd", wb_rd_o, 5'd12);
        chk("int_wb_data", wb_data_o, 32'hCAFEF00D);
        int_assert_i = 1'b0; req_valid_i = 1'b0;

        // rd==0 load and stray rvalid
        issue(32'h8000, 32'h0, 32'h0, 2'b10, 1'b0, 1'b0, 5'd0);
        grant1();
        resp(32'h12345678);
        chk("rd0_no_wb", wb_valid_o, 1'b0);
        resp(32'h87654321);
        chk("stray_no_wb", wb_valid_o, 1'b0);
        chk("stray_idle", busy_o, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
